id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Parametrised successor to the ID/EX pipeline register and compare-based hazard logic.
- Registers one decoded instruction per cycle into the EX stage.
- Tracks in-flight long-latency writers (load, mul, div) with a per-register scoreboard and an outstanding multi-cycle counter, inserting bubbles on RAW/WAW/structural hazards.
- Offers a drain handshake for fence/debug entry.
- Sits between decode/control and execute; ALU-to-ALU forwarding stays elsewhere.

Parameters:
XLEN, 32, operand/immediate width
AW, 16, program-counter width
RW, 5, register address width; NREG = 2**RW
CTRL_W, 24, opaque control bundle width (alusel, mulsel, divsel, mem, cmp fields)
MAX_MC, 1, max outstanding mul/div ops (1..7)

Ports:
clk  in  1  system clock
Rst  in  1  reset, asynchronous, active-low
dbg  in  1  debug freeze
mem_hold  in  1  memory freeze
flush  in  1  kill instruction currently in ID
id_valid  in  1  ID holds a real instruction
id_class  in  2  ALU=0, LOAD=1, MUL=2, DIV=3
id_rs1, id_rs2, id_rd  in  RW  register addresses
id_rs1_used, id_rs2_used, id_regwrite  in  1  operand use / writes rd
id_ctrl  in  CTRL_W  control bundle
id_op1, id_op2, id_imm  in  XLEN  operands, immediate
id_pc  in  AW  instruction address
ld_done  in  1  load result available
ld_rd  in  RW  load destination
mc_done  in  1  mul/div result available
mc_rd  in  RW  mul/div destination
drain_req  in  1  request pipeline quiesce (level)
id_stall  out  1  hold fetch and IF/ID
drain_ack  out  1  scoreboard empty, issue blocked
ex_valid, ex_regwrite  out  1
ex_class  out  2
ex_rd  out  RW
ex_ctrl  out  CTRL_W
ex_op1, ex_op2, ex_imm  out  XLEN
ex_pc  out  AW
sb_err  out  1  sticky protocol error

Behaviour:
- Reset (Rst=0, async): every ex_* output and ex_pc = 0, busy vector = 0, mc_cnt = 0, FSM = RUN, drain_ack = 0, sb_err = 0.
- clr_vec: one-hot of ld_rd if ld_done, OR one-hot of mc_rd if mc_done. Register 0 is never set busy.
- busy_eff = busy & ~clr_vec. The same-cycle completion bypass is required.
- Hazard conditions, all gated by id_valid:
  - raw: (id_rs1_used and rs1 != 0 and busy_eff[rs1]) or the same for rs2.
  - waw: id_regwrite and id_rd != 0 and busy_eff[id_rd].
  - struct: class in {MUL, DIV} and mc_cnt_eff == MAX_MC, where mc_cnt_eff = mc_cnt - mc_done.
- id_stall = freeze or raw or waw or struct or (FSM != RUN).
- freeze = dbg or mem_hold.
- Per-edge priority: freeze > flush > stall > issue.
  - freeze: ex_* hold. Scoreboard clears and mc_cnt decrements still apply, so completions are never lost.
  - flush or stall: bubble. ex_valid = 0, ex_regwrite = 0, ex_rd = 0, ex_ctrl/op/imm = 0, ex_class = ALU, ex_pc = id_pc. Scoreboard is not set.
  - issue (id_valid, no hazard): all id_* fields are registered into ex_*, with 1-cycle latency.
    - Set busy[id_rd] if class != ALU, id_regwrite, and id_rd != 0.
    - mc_cnt++ if class is MUL or DIV.
  - id_valid = 0 without hazard: bubble.
- Same-cycle clear and set of one register: set wins.
- Simultaneous issue and mc_done: mc_cnt is unchanged.
- flush never clears the scoreboard; older instructions still complete.
- sb_err is set, and held until reset, on:
  - ld_done or mc_done naming a non-busy register, or
  - mc_done with mc_cnt = 0.
  - The counter saturates at 0 in that case.
- Drain FSM:
  - RUN -> DRAIN when drain_req=1 (evaluated even during freeze).
  - DRAIN -> DRAINED when busy == 0 and mc_cnt == 0 after this cycle's clears.
  - DRAINED: drain_ack = 1 (registered).
  - DRAIN or DRAINED -> RUN when drain_req=0. drain_ack falls on the same edge.
  - Issue is blocked (bubbles) in DRAIN and DRAINED.
- Reset mid-operation abandons all tracked writers.

Decomposition:
- Package id_issue_pkg holds:
  - the enum iclass_t {ALU, LOAD, MUL, DIV},
  - the enum drain_st_t {RUN, DRAIN, DRAINED},
  - the bubble constant for the ex_* bundle.
- One natural sub-module, issue_scoreboard, owns the busy vector, mc_cnt, clear/set logic, hazard outputs and sb_err.
- The top level holds the ex_* register and the drain FSM.

Test Plan:
- Load-use: issue LOAD x5, then ALU reading rs1=x5 -> id_stall=1 and ex_valid=0 until ld_done ld_rd=5. The ALU issues the same cycle ld_done is high (bypass).
- Structural: MAX_MC=1, MUL x3, then DIV x4 -> DIV stalls. mc_done mc_rd=3 -> DIV issues that cycle and mc_cnt stays 1.
- Flush during hazard: stalled ALU on busy x7 with flush=1 -> bubble issued, busy[7] still 1, ex_pc=id_pc.
- Freeze: mem_hold=1 for 3 cycles with ld_done x5 in cycle 2 -> ex_* unchanged, busy[5] cleared, next instruction on x5 issues after release.
- Drain: busy[9]=1, raise drain_req -> DRAIN with bubbles. ld_done x9 -> drain_ack=1 next edge. Drop drain_req -> RUN and drain_ack=0.
- Error and reset: mc_done with mc_cnt=0 -> sb_err=1 sticky. Assert Rst=0 asynchronously mid-stall -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared types for the ID/EX issue stage: instruction classes, drain FSM
// states and the control portion of the EX bundle.
package id_issue_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } iclass_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } drain_st_t;

    // Control slice of the EX bundle; data fields of a bubble are all zero.
    typedef struct packed {
        logic    valid;
        logic    regwrite;
        iclass_t iclass;
    } ex_meta_t;

    localparam ex_meta_t EX_META_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, iclass: CLS_ALU};

    function automatic logic is_multicycle(input iclass_t c);
        return (c == CLS_MUL) || (c == CLS_DIV);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy tracking for long-latency writers plus the outstanding
// mul/div counter; produces the issue hazard and the sticky protocol error.
module issue_scoreboard
    import id_issue_pkg::*;
#(
    parameter int unsigned RW     = 5,
    parameter int unsigned MAX_MC = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ld_done_i,
    input  logic [RW-1:0] ld_rd_i,
    input  logic          mc_done_i,
    input  logic [RW-1:0] mc_rd_i,
    input  logic          chk_valid_i,
    input  iclass_t       chk_class_i,
    input  logic [RW-1:0] chk_rs1_i,
    input  logic [RW-1:0] chk_rs2_i,
    input  logic [RW-1:0] chk_rd_i,
    input  logic          chk_rs1_used_i,
    input  logic          chk_rs2_used_i,
    input  logic          chk_regwrite_i,
    input  logic          issue_i,
    output logic          hazard_c,
    output logic          empty_c,
    output logic          sb_err_o
);

    localparam int unsigned NREG = 2 ** RW;
    localparam int unsigned CW   = $clog2(MAX_MC + 1);

    logic [NREG-1:0] busy_q, busy_d, busy_eff, clr_vec, set_vec;
    logic [CW-1:0]   mc_cnt_q, mc_cnt_d, mc_cnt_eff;
    logic            sb_err_q, sb_err_d;
    logic            raw, waw, strct, err_evt;

    // Completions clear in the same cycle they are reported (bypass).
    always_comb begin
        clr_vec = '0;
        if (ld_done_i) clr_vec[ld_rd_i] = 1'b1;
        if (mc_done_i) clr_vec[mc_rd_i] = 1'b1;
        busy_eff   = busy_q & ~clr_vec;
        mc_cnt_eff = (mc_done_i && (mc_cnt_q != '0)) ? mc_cnt_q - CW'(1) : mc_cnt_q;
    end

    always_comb begin
        raw = chk_valid_i &&
              ((chk_rs1_used_i && (chk_rs1_i != '0) && busy_eff[chk_rs1_i]) ||
               (chk_rs2_used_i && (chk_rs2_i != '0) && busy_eff[chk_rs2_i]));
        waw = chk_valid_i && chk_regwrite_i && (chk_rd_i != '0) && busy_eff[chk_rd_i];
        strct = chk_valid_i && is_multicycle(chk_class_i) && (mc_cnt_eff == CW'(MAX_MC));
        hazard_c = raw || waw || strct;
    end

    // Set after clear so a register re-issued on its completion cycle stays busy.
    always_comb begin
        set_vec = '0;
        if (issue_i && (chk_class_i != CLS_ALU) && chk_regwrite_i && (chk_rd_i != '0))
            set_vec[chk_rd_i] = 1'b1;
        busy_d    = busy_eff | set_vec;
        busy_d[0] = 1'b0;
        mc_cnt_d  = mc_cnt_eff + CW'(issue_i && is_multicycle(chk_class_i));
        empty_c   = (busy_d == '0) && (mc_cnt_d == '0);
    end

    always_comb begin
        err_evt = (ld_done_i && !busy_q[ld_rd_i]) ||
                  (mc_done_i && (!busy_q[mc_rd_i] || (mc_cnt_q == '0)));
        sb_err_d = sb_err_q || err_evt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= '0;
            mc_cnt_q <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            mc_cnt_q <= mc_cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err_o = sb_err_q;

endmodule

// File: rtl/id_issue_stage.sv
// ID/EX issue register with scoreboard-based hazard bubbles, freeze/flush
// handling and a drain handshake for fence or debug entry.
module id_issue_stage
    import id_issue_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 16,
    parameter int unsigned RW     = 5,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned MAX_MC = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dbg_i,
    input  logic              mem_hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [1:0]        id_class_i,
    input  logic [RW-1:0]     id_rs1_i,
    input  logic [RW-1:0]     id_rs2_i,
    input  logic [RW-1:0]     id_rd_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              id_regwrite_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [XLEN-1:0]   id_op1_i,
    input  logic [XLEN-1:0]   id_op2_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [AW-1:0]     id_pc_i,
    input  logic              ld_done_i,
    input  logic [RW-1:0]     ld_rd_i,
    input  logic              mc_done_i,
    input  logic [RW-1:0]     mc_rd_i,
    input  logic              drain_req_i,
    output logic              id_stall_o,
    output logic              drain_ack_o,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic [1:0]        ex_class_o,
    output logic [RW-1:0]     ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [XLEN-1:0]   ex_op1_o,
    output logic [XLEN-1:0]   ex_op2_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [AW-1:0]     ex_pc_o,
    output logic              sb_err_o
);

    iclass_t   id_class;
    drain_st_t state_q, state_d;
    ex_meta_t  ex_meta_q, ex_meta_d;
    logic [RW-1:0]     ex_rd_q, ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [XLEN-1:0]   ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d, ex_imm_q, ex_imm_d;
    logic [AW-1:0]     ex_pc_q, ex_pc_d;
    logic              drain_ack_q, drain_ack_d;
    logic              freeze, hazard, sb_empty, issue;

    assign id_class = iclass_t'(id_class_i);
    assign freeze   = dbg_i || mem_hold_i;
    assign issue    = !freeze && !flush_i && id_valid_i && !hazard && (state_q == ST_RUN);

    issue_scoreboard #(
        .RW     (RW),
        .MAX_MC (MAX_MC)
    ) u_sb (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ld_done_i      (ld_done_i),
        .ld_rd_i        (ld_rd_i),
        .mc_done_i      (mc_done_i),
        .mc_rd_i        (mc_rd_i),
        .chk_valid_i    (id_valid_i),
        .chk_class_i    (id_class),
        .chk_rs1_i      (id_rs1_i),
        .chk_rs2_i      (id_rs2_i),
        .chk_rd_i       (id_rd_i),
        .chk_rs1_used_i (id_rs1_used_i),
        .chk_rs2_used_i (id_rs2_used_i),
        .chk_regwrite_i (id_regwrite_i),
        .issue_i        (issue),
        .hazard_c       (hazard),
        .empty_c        (sb_empty),
        .sb_err_o       (sb_err_o)
    );

    // Stall must reach fetch in the same cycle, so it is a combinational output.
    assign id_stall_o = freeze || hazard || (state_q != ST_RUN);

    // EX bundle: freeze holds, otherwise issue or insert a bubble at id_pc.
    always_comb begin
        ex_meta_d = ex_meta_q;
        ex_rd_d   = ex_rd_q;
        ex_ctrl_d = ex_ctrl_q;
        ex_op1_d  = ex_op1_q;
        ex_op2_d  = ex_op2_q;
        ex_imm_d  = ex_imm_q;
        ex_pc_d   = ex_pc_q;
        if (!freeze) begin
            if (issue) begin
                ex_meta_d = '{valid: 1'b1, regwrite: id_regwrite_i, iclass: id_class};
                ex_rd_d   = id_rd_i;
                ex_ctrl_d = id_ctrl_i;
                ex_op1_d  = id_op1_i;
                ex_op2_d  = id_op2_i;
                ex_imm_d  = id_imm_i;
            end else begin
                ex_meta_d = EX_META_BUBBLE;
                ex_rd_d   = '0;
                ex_ctrl_d = '0;
                ex_op1_d  = '0;
                ex_op2_d  = '0;
                ex_imm_d  = '0;
            end
            ex_pc_d = id_pc_i;
        end
    end

    // Drain FSM runs regardless of freeze; dropping drain_req always returns to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:     if (drain_req_i) state_d = ST_DRAIN;
            ST_DRAIN:   if (!drain_req_i) state_d = ST_RUN;
                        else if (sb_empty) state_d = ST_DRAINED;
            ST_DRAINED: if (!drain_req_i) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        drain_ack_d = (state_d == ST_DRAINED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            drain_ack_q <= 1'b0;
            ex_meta_q   <= EX_META_BUBBLE;
            ex_rd_q     <= '0;
            ex_ctrl_q   <= '0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_imm_q    <= '0;
            ex_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_ack_q <= drain_ack_d;
            ex_meta_q   <= ex_meta_d;
            ex_rd_q     <= ex_rd_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            ex_imm_q    <= ex_imm_d;
            ex_pc_q     <= ex_pc_d;
        end
    end

    assign drain_ack_o   = drain_ack_q;
    assign ex_valid_o    = ex_meta_q.valid;
    assign ex_regwrite_o = ex_meta_q.regwrite;
    assign ex_class_o    = ex_meta_q.iclass;
    assign ex_rd_o       = ex_rd_q;
    assign ex_ctrl_o     = ex_ctrl_q;
    assign ex_op1_o      = ex_op1_q;
    assign ex_op2_o      = ex_op2_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_pc_o       = ex_pc_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed scenarios plus randomized traffic for id_issue_stage, checked
// against a behavioural scoreboard model kept in the bench.
module tb_id_issue_stage;

    localparam int XLEN = 32, AW = 16, RW = 5, CTRL_W = 24, MAX_MC = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic dbg, mem_hold, flush, id_valid, rs1_used, rs2_used, regwrite;
    logic [1:0] id_class;
    logic [RW-1:0] rs1, rs2, rd, ld_rd, mc_rd;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0] op1, op2, imm;
    logic [AW-1:0] pc;
    logic ld_done, mc_done, drain_req;

    logic id_stall, drain_ack, ex_valid, ex_regwrite, sb_err;
    logic [1:0] ex_class;
    logic [RW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0] ex_op1, ex_op2, ex_imm;
    logic [AW-1:0] ex_pc;

    id_issue_stage #(.XLEN(XLEN), .AW(AW), .RW(RW), .CTRL_W(CTRL_W), .MAX_MC(MAX_MC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dbg_i(dbg), .mem_hold_i(mem_hold), .flush_i(flush),
        .id_valid_i(id_valid), .id_class_i(id_class), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rd_i(rd), .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .id_regwrite_i(regwrite), .id_ctrl_i(ctrl), .id_op1_i(op1), .id_op2_i(op2),
        .id_imm_i(imm), .id_pc_i(pc), .ld_done_i(ld_done), .ld_rd_i(ld_rd),
        .mc_done_i(mc_done), .mc_rd_i(mc_rd), .drain_req_i(drain_req),
        .id_stall_o(id_stall), .drain_ack_o(drain_ack), .ex_valid_o(ex_valid),
        .ex_regwrite_o(ex_regwrite), .ex_class_o(ex_class), .ex_rd_o(ex_rd),
        .ex_ctrl_o(ex_ctrl), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_imm_o(ex_imm),
        .ex_pc_o(ex_pc), .sb_err_o(sb_err)
    );

    // Reference model: owner[r] is 0 (free), 1 (pending load) or 2 (pending mul/div).
    int owner_m[32];
    int mc_m, st_m;
    bit ack_m, err_m, exv_m, exw_m;
    int exc_m, exrd_m;
    logic [CTRL_W-1:0] exctrl_m;
    logic [XLEN-1:0] exop1_m, exop2_m, eximm_m;
    logic [AW-1:0] expc_m;
    logic last_stall;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy_after_clear(input int r);
        if (owner_m[r] == 0) return 1'b0;
        if (ld_done && int'(ld_rd) == r) return 1'b0;
        if (mc_done && int'(mc_rd) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int mc_after_done();
        return (mc_done && mc_m > 0) ? mc_m - 1 : mc_m;
    endfunction

    function automatic bit model_hazard();
        if (!id_valid) return 1'b0;
        if (rs1_used && rs1 != 0 && busy_after_clear(int'(rs1))) return 1'b1;
        if (rs2_used && rs2 != 0 && busy_after_clear(int'(rs2))) return 1'b1;
        if (regwrite && rd != 0 && busy_after_clear(int'(rd))) return 1'b1;
        if (id_class >= 2 && mc_after_done() == MAX_MC) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) owner_m[r] = 0;
        mc_m = 0; st_m = 0; ack_m = 0; err_m = 0;
        exv_m = 0; exw_m = 0; exc_m = 0; exrd_m = 0;
        exctrl_m = '0; exop1_m = '0; exop2_m = '0; eximm_m = '0; expc_m = '0;
    endtask

    task automatic idle_inputs();
        dbg = 0; mem_hold = 0; flush = 0; id_valid = 0; id_class = 0;
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0; regwrite = 0;
        ctrl = '0; op1 = '0; op2 = '0; imm = '0; pc = '0;
        ld_done = 0; ld_rd = 0; mc_done = 0; mc_rd = 0; drain_req = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_ex_valid"}, ex_valid, exv_m);
        check({pfx, "_ex_regwrite"}, ex_regwrite, exw_m);
        check({pfx, "_ex_class"}, ex_class, exc_m);
        check({pfx, "_ex_rd"}, ex_rd, exrd_m);
        check({pfx, "_ex_ctrl"}, ex_ctrl, exctrl_m);
        check({pfx, "_ex_ops"}, {ex_op1, ex_op2}, {exop1_m, exop2_m});
        check({pfx, "_ex_imm"}, ex_imm, eximm_m);
        check({pfx, "_ex_pc"}, ex_pc, expc_m);
        check({pfx, "_drain_ack"}, drain_ack, ack_m);
        check({pfx, "_sb_err"}, sb_err, err_m);
    endtask

    // One clock: check stall at the negedge, advance the model, check registers after the posedge.
    task automatic step();
        bit hz, frz, iss, empty;
        int nown[32];
        @(negedge clk);
        hz  = model_hazard();
        frz = dbg || mem_hold;
        iss = !frz && !flush && id_valid && !hz && st_m == 0;
        last_stall = id_stall;
        check("id_stall", id_stall, frz || hz || st_m != 0);
        if (ld_done && owner_m[ld_rd] == 0) err_m = 1;
        if (mc_done && (owner_m[mc_rd] == 0 || mc_m == 0)) err_m = 1;
        for (int r = 0; r < 32; r++) nown[r] = busy_after_clear(r) ? owner_m[r] : 0;
        if (iss && id_class != 0 && regwrite && rd != 0) nown[rd] = (id_class == 1) ? 1 : 2;
        mc_m = mc_after_done() + ((iss && id_class >= 2) ? 1 : 0);
        owner_m = nown;
        if (!frz) begin
            exv_m = iss; exw_m = iss && regwrite; exc_m = iss ? int'(id_class) : 0;
            exrd_m = iss ? int'(rd) : 0;
            exctrl_m = iss ? ctrl : '0;
            exop1_m = iss ? op1 : '0; exop2_m = iss ? op2 : '0; eximm_m = iss ? imm : '0;
            expc_m = pc;
        end
        empty = (mc_m == 0);
        for (int r = 0; r < 32; r++) if (owner_m[r] != 0) empty = 0;
        case (st_m)
            0: if (drain_req) st_m = 1;
            1: if (!drain_req) st_m = 0; else if (empty) st_m = 2;
            default: if (!drain_req) st_m = 0;
        endcase
        ack_m = (st_m == 2);
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #3;
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int cls, input int d, input int s1, input bit u1, input int p);
        id_valid = 1; id_class = 2'(cls); rd = RW'(d); regwrite = (d != 0);
        rs1 = RW'(s1); rs1_used = u1; rs2 = 0; rs2_used = 0; pc = AW'(p);
        ctrl = CTRL_W'($urandom); op1 = $urandom; op2 = $urandom; imm = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Load-use with same-cycle completion bypass.
        set_instr(1, 5, 0, 0, 'h100); step();
        check("lu_load_issued", ex_valid, 1);
        set_instr(0, 6, 5, 1, 'h104); step();
        check("lu_stall", last_stall, 1);
        check("lu_bubble", ex_valid, 0);
        step();
        ld_done = 1; ld_rd = 5; step();
        check("lu_bypass_stall", last_stall, 0);
        check("lu_bypass_issue", ex_valid, 1);
        check("lu_bypass_pc", ex_pc, 'h104);
        ld_done = 0; id_valid = 0; step();

        // Structural hazard with a single mul/div slot.
        set_instr(2, 3, 0, 0, 'h120); step();
        set_instr(3, 4, 0, 0, 'h124); step();
        check("st_div_stall", last_stall, 1);
        mc_done = 1; mc_rd = 3; step();
        check("st_div_issue", ex_valid, 1);
        check("st_div_class", ex_class, 3);
        mc_done = 0; set_instr(2, 8, 0, 0, 'h128); step();
        check("st_slot_full", last_stall, 1);
        id_valid = 0; mc_done = 1; mc_rd = 4; step();
        mc_done = 0; step();

        // Flush while stalled keeps the scoreboard.
        set_instr(1, 7, 0, 0, 'h200); step();
        set_instr(0, 1, 7, 1, 'h204); flush = 1; step();
        check("fl_bubble", ex_valid, 0);
        check("fl_pc", ex_pc, 'h204);
        flush = 0; step();
        check("fl_still_busy", last_stall, 1);
        ld_done = 1; ld_rd = 7; id_valid = 0; step();
        ld_done = 0;

        // Freeze holds EX while completions still land.
        set_instr(1, 5, 0, 0, 'h300); step();
        set_instr(0, 2, 5, 1, 'h304); mem_hold = 1; step();
        ld_done = 1; ld_rd = 5; step();
        ld_done = 0; step();
        check("fz_hold_pc", ex_pc, 'h300);
        check("fz_hold_valid", ex_valid, 1);
        mem_hold = 0; step();
        check("fz_release_issue", ex_valid, 1);
        check("fz_release_pc", ex_pc, 'h304);
        id_valid = 0; step();

        // Drain handshake.
        set_instr(1, 9, 0, 0, 'h400); step();
        id_valid = 0; drain_req = 1; step();
        check("dr_no_ack", drain_ack, 0);
        set_instr(0, 2, 0, 0, 'h404); step();
        check("dr_blocked", ex_valid, 0);
        ld_done = 1; ld_rd = 9; step();
        check("dr_ack", drain_ack, 1);
        ld_done = 0; step();
        drain_req = 0; step();
        check("dr_ack_drop", drain_ack, 0);
        step();
        check("dr_resume", ex_valid, 1);
        id_valid = 0; step();

        // Sticky protocol error.
        do_reset();
        mc_done = 1; mc_rd = 2; step();
        check("err_set", sb_err, 1);
        mc_done = 0; step();
        check("err_sticky", sb_err, 1);

        // Asynchronous reset while stalled.
        do_reset();
        set_instr(1, 5, 0, 0, 'h500); step();
        set_instr(0, 6, 5, 1, 'h504); step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("ar_stall", id_stall, 0);
        check_outputs("arst");
        do_reset();

        // Randomized traffic with legal completions.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int cand[$];
            dbg      = ($urandom % 16) == 0;
            mem_hold = ($urandom % 10) == 0;
            flush    = ($urandom % 12) == 0;
            drain_req = ((cyc / 50) % 5) == 4;
            id_valid = ($urandom % 4) != 0;
            id_class = 2'($urandom);
            rs1 = RW'($urandom_range(0, 7)); rs2 = RW'($urandom_range(0, 7));
            rs1_used = 1'($urandom); rs2_used = 1'($urandom);
            rd = RW'($urandom_range(0, 7)); regwrite = 1'($urandom);
            if (id_class >= 2) begin
                rd = RW'($urandom_range(1, 7)); regwrite = 1;
            end
            ctrl = CTRL_W'($urandom); op1 = $urandom; op2 = $urandom; imm = $urandom;
            pc = AW'($urandom);
            ld_done = 0; mc_done = 0;
            cand.delete();
            for (int r = 1; r < 32; r++) if (owner_m[r] == 1) cand.push_back(r);
            if (cand.size() > 0 && ($urandom % 3) == 0) begin
                ld_done = 1; ld_rd = RW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            cand.delete();
            for (int r = 1; r < 32; r++) if (owner_m[r] == 2) cand.push_back(r);
            if (cand.size() > 0 && mc_m > 0 && ($urandom % 3) == 0) begin
                mc_done = 1; mc_rd = RW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
